pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Pipeline controller for the 5-stage RV64 core. It sequences instruction_decode and the EX/MEM/WB datapath.
- Keeps its own shadow copy of the register-use fields for the instructions in the EX, MEM and WB stages.
- From that shadow it generates the PC and IF/ID write enables, the IF/ID flush, the ID/EX bubble insertion, and the ALU operand forwarding selects.
- Also counts stall and flush events for performance debug.

Parameters:
- CNT_W, 16, width of the saturating stall and flush event counters.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- id_valid  input  1  IF/ID register holds a real instruction.
- id_inst  input  32  instruction currently in ID (same word fed to instruction_decode).
- ex_zero  input  1  ALU zero flag for the instruction in EX.
- mem_busy  input  1  data memory not ready; the whole pipeline must freeze.
- pc_write  output  1  PC register load enable.
- ifid_write  output  1  IF/ID register load enable.
- ifid_flush  output  1  clear IF/ID to NOP on next edge.
- idex_bubble  output  1  load zeros (NOP controls) into ID/EX on next edge.
- fwd_a  output  2  ALU operand A select: 00 regfile, 10 EX/MEM result, 01 MEM/WB result.
- fwd_b  output  2  ALU operand B select; same encoding as fwd_a.
- stall_cnt  output  CNT_W  load-use stall cycles, saturating.
- flush_cnt  output  CNT_W  taken-branch flushes, saturating.

Behaviour:
- ID decode, internal:
  - rs1 = inst[19:15], rs2 = inst[24:20], rd = inst[11:7].
  - use_rs1 for opcodes 0110011, 0000011, 0100011, 1100011.
  - use_rs2 for 0110011, 0100011, 1100011.
  - regwrite for 0110011 and 0000011.
  - memread for 0000011.
  - branch for 1100011.
  - All flags are 0 when id_valid=0 or the opcode is unknown.
- Shadow state, one entry per stage:
  - EX entry holds {rs1, rs2, use_rs1, use_rs2, rd, regwrite, memread, branch}.
  - MEM and WB entries hold {rd, regwrite}.
- Derived conditions:
  - br_taken = EX.branch & ex_zero.
  - load_use = EX.memread & EX.rd≠0 & ((use_rs1 & EX.rd==id rs1) | (use_rs2 & EX.rd==id rs2)).
- Output priority, combinational from current state and inputs:
  1. mem_busy=1:
     - pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0.
     - Shadow holds; counters hold.
  2. br_taken:
     - pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1.
     - flush_cnt+1.
     - A load_use in the same cycle is ignored (the ID instruction is discarded).
  3. load_use:
     - pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1.
     - stall_cnt+1.
  4. Otherwise: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- Shadow advance on every posedge with mem_busy=0:
  - WB ← MEM, MEM ← EX.
  - EX ← all-zero when idex_bubble, else the ID decode.
- Forwarding, per operand (shown for A using EX.rs1/use_rs1; B uses rs2/use_rs2):
  - 10 if MEM.regwrite & MEM.rd≠0 & MEM.rd==EX.rs1 & EX.use_rs1.
  - else 01 if WB.regwrite & WB.rd≠0 & WB.rd==EX.rs1 & EX.use_rs1.
  - else 00.
  - MEM has priority over WB (youngest producer wins).
  - fwd outputs are valid during mem_busy.
- No WB→ID forwarding: the register file writes on negedge, so ID reads the new value in the same cycle.
- x0 never causes a stall or a forward.
- Counters saturate at all-ones and do not wrap.
- Latency: all control outputs are combinational, zero-cycle. The shadow reflects pipeline contents one edge after each advance.
- Reset:
  - Synchronous rst=1 clears all shadow entries and both counters, and has priority over mem_busy.
  - Post-reset outputs: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, fwd_a=fwd_b=00, stall_cnt=flush_cnt=0.
  - Reset in the middle of a stall or flush discards the pending event.

Decomposition:
- Shared package/include `riscv_pkg` holds:
  - opcode constants OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH.
  - FWD_REG/FWD_EXMEM/FWD_MEMWB select encodings.
  - the EX shadow-entry record layout.
- One natural sub-module, `pipe_shadow_regs`: the three-entry shadow shift register, with hold (mem_busy), bubble insert and sync reset.
- Hazard decode, forwarding compare, priority logic and counters stay in the top module.

Test Plan:
- Reset, then 3 independent adds (x1..x3 ← x0 sources):
  - pc_write/ifid_write=1 every cycle, fwd_a=fwd_b=00, counters 0.
- `add x5,x1,x2` followed by `add x6,x5,x5`:
  - when the second add is in EX, fwd_a=fwd_b=10.
  - with one unrelated instruction in between: fwd_a=fwd_b=01.
- `ld x7,8(x2)` followed by `add x8,x7,x1`:
  - exactly one cycle with pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt=1.
  - next cycle the add is in EX with fwd_a=01.
- `beq x1,x1,off` reaching EX with ex_zero=1:
  - ifid_flush=1 and idex_bubble=1 for one cycle; flush_cnt=1.
  - with ex_zero=0: no flush, counters unchanged.
- Load-use pair with mem_busy=1 held 3 cycles:
  - all enables 0, shadow frozen, stall_cnt unchanged.
  - after release, the one-cycle stall occurs; stall_cnt=1.
- Destination x0:
  - `ld x0,0(x2)` then `add x9,x0,x0` gives no stall and fwd=00.
  - Assert rst mid-stall: next cycle all outputs at reset values.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV64 pipeline definitions: opcodes, forwarding encodings, shadow-entry
// layouts and the ID-stage register-use decode.
package riscv_pkg;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       use_rs1;
      logic       use_rs2;
      logic [4:0] rd;
      logic       regwrite;
      logic       memread;
      logic       branch;
   } ex_entry_t;

   typedef struct packed {
      logic [4:0] rd;
      logic       regwrite;
   } wb_entry_t;

   function automatic ex_entry_t decode_id(input logic valid, input logic [31:0] inst);
      ex_entry_t e;
      e          = '0;
      e.rs1      = inst[19:15];
      e.rs2      = inst[24:20];
      e.rd       = inst[11:7];
      if (valid) begin
         case (inst[6:0])
            OP_RTYPE: begin
               e.use_rs1  = 1'b1;
               e.use_rs2  = 1'b1;
               e.regwrite = 1'b1;
            end
            OP_LOAD: begin
               e.use_rs1  = 1'b1;
               e.regwrite = 1'b1;
               e.memread  = 1'b1;
            end
            OP_STORE: begin
               e.use_rs1  = 1'b1;
               e.use_rs2  = 1'b1;
            end
            OP_BRANCH: begin
               e.use_rs1  = 1'b1;
               e.use_rs2  = 1'b1;
               e.branch   = 1'b1;
            end
            default: ;
         endcase
      end
      return e;
   endfunction

endpackage

// File: rtl/pipe_shadow_regs.sv
// Three-entry shadow of the EX/MEM/WB register-use fields; freezes on hold,
// loads an empty EX entry on bubble, clears on synchronous reset.
module pipe_shadow_regs
   import riscv_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      hold_i,
   input  logic      bubble_i,
   input  ex_entry_t id_entry_i,
   output ex_entry_t ex_o,
   output wb_entry_t mem_o,
   output wb_entry_t wb_o
);

   ex_entry_t ex_q, ex_d;
   wb_entry_t mem_q, mem_d;
   wb_entry_t wb_q, wb_d;

   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      if (!hold_i) begin
         wb_d           = mem_q;
         mem_d.rd       = ex_q.rd;
         mem_d.regwrite = ex_q.regwrite;
         ex_d           = bubble_i ? ex_entry_t'('0) : id_entry_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

   assign ex_o  = ex_q;
   assign mem_o = mem_q;
   assign wb_o  = wb_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage core: stall/flush enables, ALU operand
// forwarding selects and saturating stall/flush event counters.
module pipe_hazard_ctrl
   import riscv_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [31:0]      id_inst,
   input  logic             ex_zero,
   input  logic             mem_busy,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   ex_entry_t id_e;
   ex_entry_t ex_e;
   wb_entry_t mem_e;
   wb_entry_t wb_e;

   logic br_taken;
   logic load_use;
   logic rs1_hit;
   logic rs2_hit;

   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   assign id_e = decode_id(id_valid, id_inst);

   pipe_shadow_regs u_shadow (
      .clk        (clk),
      .rst        (rst),
      .hold_i     (mem_busy),
      .bubble_i   (idex_bubble),
      .id_entry_i (id_e),
      .ex_o       (ex_e),
      .mem_o      (mem_e),
      .wb_o       (wb_e)
   );

   assign rs1_hit  = id_e.use_rs1 & (ex_e.rd == id_e.rs1);
   assign rs2_hit  = id_e.use_rs2 & (ex_e.rd == id_e.rs2);
   assign br_taken = ex_e.branch & ex_zero;
   assign load_use = ex_e.memread & (ex_e.rd != 5'd0) & (rs1_hit | rs2_hit);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (mem_busy) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
      end else if (br_taken) begin
         // taken branch wins: the ID instruction is discarded, so its load-use is moot
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         flush_cnt_d = sat_inc(flush_cnt_q);
      end else if (load_use) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
         stall_cnt_d = sat_inc(stall_cnt_q);
      end
   end

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic use_rs,
                                          input wb_entry_t mem, input wb_entry_t wb);
      if (use_rs && mem.regwrite && mem.rd != 5'd0 && mem.rd == rs)
         return FWD_EXMEM;
      else if (use_rs && wb.regwrite && wb.rd != 5'd0 && wb.rd == rs)
         return FWD_MEMWB;
      else
         return FWD_REG;
   endfunction

   assign fwd_a = fwd_sel(ex_e.rs1, ex_e.use_rs1, mem_e, wb_e);
   assign fwd_b = fwd_sel(ex_e.rs2, ex_e.use_rs2, mem_e, wb_e);

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule
